// File: rtl/fc_argmax_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : fc_argmax_classifier
//  Description : Snapshots the packed class-score vector on start, scans it one
//                class per cycle and reports the index of the largest signed
//                score. Optional macro FC_ARGMAX_SCORE_OUT_EN adds max_score.
//  Revision    : 1.0 - initial release
// ============================================================================
module fc_argmax_classifier #(
  parameter int NUM_CLASS = 10,
  parameter int DATA_W    = 16,
  parameter int IDX_W     = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NUM_CLASS*DATA_W-1:0]   data_in,
  output logic [IDX_W-1:0]              class_id,
`ifdef FC_ARGMAX_SCORE_OUT_EN
  output logic signed [DATA_W-1:0]      max_score,
`endif
  output logic                          busy,
  output logic                          ready
);

  localparam logic [1:0]       c_idle     = 2'd0;
  localparam logic [1:0]       c_scan     = 2'd1;
  localparam logic [1:0]       c_done     = 2'd2;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_CLASS - 1);

  logic [1:0]                  r_state;
  logic [NUM_CLASS*DATA_W-1:0] r_snap;
  logic [IDX_W-1:0]            r_idx;
  logic [IDX_W-1:0]            r_best_idx;
  logic signed [DATA_W-1:0]    r_best_val;
  logic [IDX_W-1:0]            r_class_id;
  logic                        r_busy;
  logic                        r_ready;
  logic signed [DATA_W-1:0]    w_score;
  logic                        w_better;
`ifdef FC_ARGMAX_SCORE_OUT_EN
  logic signed [DATA_W-1:0]    r_max_score;
`endif

  // Select the snapshot score addressed by the scan index.
  always_comb begin
    w_score = '0;
    for (int k = 0; k < NUM_CLASS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_score = r_snap[k*DATA_W +: DATA_W];
      end
    end
  end

  // Strict compare keeps the lowest index among equal maxima.
  assign w_better = (w_score > r_best_val);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state     <= c_idle;
      r_snap      <= '0;
      r_idx       <= '0;
      r_best_idx  <= '0;
      r_best_val  <= '0;
      r_class_id  <= '0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b0;
`ifdef FC_ARGMAX_SCORE_OUT_EN
      r_max_score <= '0;
`endif
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        c_idle: begin
          if (start) begin
            r_snap     <= data_in;
            r_best_val <= data_in[DATA_W-1:0];
            r_best_idx <= '0;
            r_idx      <= IDX_W'(1);
            r_busy     <= 1'b1;
            r_state    <= c_scan;
          end
        end
        c_scan: begin
          if (w_better) begin
            r_best_val <= w_score;
            r_best_idx <= r_idx;
          end
          if (r_idx == c_last_idx) begin
            r_state <= c_done;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        c_done: begin
          r_class_id  <= r_best_idx;
`ifdef FC_ARGMAX_SCORE_OUT_EN
          r_max_score <= r_best_val;
`endif
          r_ready     <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= c_idle;
        end
        default: begin
          r_state <= c_idle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign class_id = r_class_id;
  assign busy     = r_busy;
  assign ready    = r_ready;
`ifdef FC_ARGMAX_SCORE_OUT_EN
  assign max_score = r_max_score;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fc_argmax_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fc_argmax_classifier
//  Description : Self-checking bench for fc_argmax_classifier (vector table,
//                result scoreboard, multi-cycle corner sequences).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_argmax_classifier;

  localparam int NUM_CLASS = 10;
  localparam int DATA_W    = 16;
  localparam int IDX_W     = 4;
  localparam int VW        = NUM_CLASS * DATA_W;
  localparam int NUM_TV    = 5;

  typedef struct {
    logic [VW-1:0] data;
    int            exp_id;
    int            exp_score;
    string         name;
  } vec_t;

  typedef struct {
    int id;
    int score;
  } res_t;

  logic                     clk;
  logic                     rst_n;
  logic                     start;
  logic [VW-1:0]            data_in;
  logic [IDX_W-1:0]         class_id;
  logic signed [DATA_W-1:0] max_score;
  logic                     busy;
  logic                     ready;

  int   checks  = 0;
  int   errors  = 0;
  int   n_ready = 0;
  int   last_id = 0;
  res_t q[$];

  fc_argmax_classifier #(
    .NUM_CLASS (NUM_CLASS),
    .DATA_W    (DATA_W),
    .IDX_W     (IDX_W)
  ) dut (
    .clk_in    (clk),
    .rst_n     (rst_n),
    .start     (start),
    .data_in   (data_in),
    .class_id  (class_id),
`ifdef FC_ARGMAX_SCORE_OUT_EN
    .max_score (max_score),
`endif
    .busy      (busy),
    .ready     (ready)
  );

`ifndef FC_ARGMAX_SCORE_OUT_EN
  assign max_score = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] mk(input int s [NUM_CLASS]);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_CLASS; k++) v[k*DATA_W +: DATA_W] = DATA_W'(s[k]);
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vec(input bit narrow);
    logic [VW-1:0] v;
    for (int k = 0; k < NUM_CLASS; k++) begin
      if (narrow) v[k*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 4)) - DATA_W'(2);
      else        v[k*DATA_W +: DATA_W] = DATA_W'($urandom);
    end
    return v;
  endfunction

  // Reference argmax: first strictly larger signed score wins.
  function automatic res_t model(input logic [VW-1:0] d);
    res_t r;
    logic signed [DATA_W-1:0] s;
    s       = d[DATA_W-1:0];
    r.id    = 0;
    r.score = int'(s);
    for (int k = 1; k < NUM_CLASS; k++) begin
      s = d[k*DATA_W +: DATA_W];
      if (int'(s) > r.score) begin
        r.score = int'(s);
        r.id    = k;
      end
    end
    return r;
  endfunction

  // Result checker: every ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ready) begin
      res_t e;
      n_ready++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: class_id %0d with no result pending", class_id);
      end else begin
        e = q.pop_front();
        chk("result_class_id", int'(class_id), e.id);
`ifdef FC_ARGMAX_SCORE_OUT_EN
        chk("result_max_score", int'(max_score), e.score);
`endif
      end
    end
  end

  // Drive start for one cycle from a negedge; returns at the negedge after the start edge.
  task automatic pulse_start(input logic [VW-1:0] d, input bit push, input res_t e);
    data_in = d;
    start   = 1'b1;
    if (push) q.push_back(e);
    @(negedge clk);
    start   = 1'b0;
    data_in = rand_vec(1'b0);
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_ready(input string name, input int c0, input int exp_id);
    int c;
    c = c0;
    while (!ready && c < 40) begin
      @(negedge clk);
      c++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no ready after %0d cycles, expected at %0d", name, c, NUM_CLASS + 1);
    end else begin
      chk({name, "_latency"}, c, NUM_CLASS + 1);
      chk({name, "_busy_low"}, int'(busy), 0);
      last_id = exp_id;
    end
  endtask

  initial begin
    vec_t          tv [NUM_TV];
    int            a [NUM_CLASS];
    logic [VW-1:0] va, vb, vc, vd;
    res_t          e;
    int            nr;

    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = '0;

    a = '{3, -7, 12, 5, 0, 100, -1, 99, 42, 7};
    tv[0] = '{mk(a), 5, 100, "single_max"};
    for (int k = 0; k < NUM_CLASS; k++) a[k] = -32768;
    a[2] = -5;
    a[8] = -5;
    tv[1] = '{mk(a), 2, -5, "signed_tie"};
    for (int k = 0; k < NUM_CLASS; k++) a[k] = 0;
    tv[2] = '{mk(a), 0, 0, "all_zero"};
    a[9] = 32767;
    tv[3] = '{mk(a), 9, 32767, "last_index"};
    for (int k = 0; k < NUM_CLASS; k++) a[k] = -32768;
    tv[4] = '{mk(a), 0, -32768, "all_min"};

    // Reset then idle
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("reset_class_id", int'(class_id), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ready", int'(ready), 0);
    chk("reset_no_ready_pulse", n_ready, 0);
`ifdef FC_ARGMAX_SCORE_OUT_EN
    chk("reset_max_score", int'(max_score), 0);
`endif

    // Table vectors; data_in is scrambled right after each start
    for (int i = 0; i < NUM_TV; i++) begin
      e.id    = tv[i].exp_id;
      e.score = tv[i].exp_score;
      pulse_start(tv[i].data, 1'b1, e);
      wait_ready(tv[i].name, 1, e.id);
      @(negedge clk);
    end

    // Random vectors, wide range and tie-heavy narrow range
    for (int i = 0; i < 6; i++) begin
      va = rand_vec(i[0]);
      e  = model(va);
      pulse_start(va, 1'b1, e);
      wait_ready("random", 1, e.id);
      @(negedge clk);
    end

    // Busy rejection followed by a start in the ready cycle
    for (int k = 0; k < NUM_CLASS; k++) a[k] = k;
    a[3] = 500;
    va = mk(a);
    a[3] = 0;
    a[6] = 900;
    vb = mk(a);
    for (int k = 0; k < NUM_CLASS; k++) a[k] = -k;
    a[7] = 77;
    vc = mk(a);
    pulse_start(va, 1'b1, model(va));
    repeat (3) @(negedge clk);
    chk("class_id_held_mid_scan", int'(class_id), last_id);
    pulse_start(vb, 1'b0, model(vb));
    wait_ready("reject", 5, 3);
    pulse_start(vc, 1'b1, model(vc));
    wait_ready("back_to_back", 1, 7);
    @(negedge clk);
    nr = n_ready;
    repeat (15) @(negedge clk);
    chk("no_extra_ready", n_ready, nr);

    // Reset in the middle of a scan
    for (int k = 0; k < NUM_CLASS; k++) a[k] = 10 * k - 40;
    a[4] = 1234;
    vd = mk(a);
    pulse_start(vd, 1'b1, model(vd));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_class_id", int'(class_id), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_ready", int'(ready), 0);
`ifdef FC_ARGMAX_SCORE_OUT_EN
    chk("midreset_max_score", int'(max_score), 0);
`endif
    nr = n_ready;
    repeat (15) @(negedge clk);
    chk("midreset_no_ready", n_ready, nr);
    pulse_start(vd, 1'b1, model(vd));
    wait_ready("after_reset", 1, 4);
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fc_argmax_classifier.md
# fc_argmax_classifier

Final stage of the CNN pipeline, directly downstream of the full-connection layer. Captures the packed vector of per-class scores when the full-connection stage pulses ready, scans it serially one class per cycle, and reports the index of the largest signed score as the network's classification result. Single clock domain (`clk_200` at top level). One result per start.

## Interface
Parameters:
- NUM_CLASS, 10, number of class scores in `data_in` (≥2)
- DATA_W, 16, width of one signed two's-complement score
- IDX_W, 4, width of `class_id`; must satisfy 2^IDX_W ≥ NUM_CLASS

Ports:
- clk_in  input  1  clock; all logic on rising edge
- rst_n  input  1  reset; synchronous, active-low
- start  input  1  one-cycle pulse: `data_in` valid this cycle (driven by full-connection ready)
- data_in  input  NUM_CLASS*DATA_W  packed scores; class k at bits [k*DATA_W +: DATA_W]
- class_id  output  IDX_W  index of winning class; held until next result
- max_score  output  DATA_W  winning score, signed (only with FC_ARGMAX_SCORE_OUT_EN)
- busy  output  1  high while a scan is in progress
- ready  output  1  one-cycle pulse: `class_id` (and `max_score`) newly valid

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: `busy`=0. On `start`=1: snapshot full `data_in` into internal register; best_val←class 0 score, best_idx←0, idx←1; go to SCAN.
- SCAN: `busy`=1. Each cycle compare score[idx] against best_val, signed. If score[idx] > best_val (strict), best_val←score[idx], best_idx←idx. If idx == NUM_CLASS-1 go to DONE, else idx←idx+1.
- DONE: `busy`=1. Load `class_id`←best_idx, `max_score`←best_val; assert `ready` for exactly this transition's following cycle; return to IDLE.
- Ties: strict compare, so lowest index among equal maxima wins.
- Arithmetic: comparison only, no overflow possible; all scores treated as signed DATA_W.
- `start` while busy (SCAN or DONE): ignored, no queuing, snapshot untouched.
- `data_in` is sampled only on the accepted `start` cycle; later changes have no effect.
- Reset (`rst_n`=0 at a rising edge), including mid-scan: state←IDLE, `class_id`←0, `max_score`←0, `busy`←0, `ready`←0, idx←0, snapshot cleared; in-flight result discarded, no `ready` pulse.

## Timing
- Reset values: `class_id`=0, `max_score`=0, `busy`=0, `ready`=0.
- Let edge E0 sample `start`=1 in IDLE. `busy` high after E0. SCAN occupies NUM_CLASS-1 cycles (edges E1..E(NUM_CLASS-1) perform the compares). DONE follows; `ready`=1 and new `class_id` visible after edge E(NUM_CLASS). With NUM_CLASS=10: `ready` high in the 10th cycle after the start edge, for one cycle.
- `busy` falls in the same edge `ready` rises; block accepts a new `start` in the cycle `ready` is high (back-to-back throughput: one result per NUM_CLASS+1 cycles... precisely, next accepted start may be sampled on the edge ending the `ready` cycle).
- `class_id`/`max_score` change only at the edge that raises `ready` or at reset.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- FC_ARGMAX_SCORE_OUT_EN defined: `max_score` port and its output register present, behaving as above.
- Not defined: `max_score` port absent; best_val kept only internally for comparison; all other behaviour and timing identical.

## Test plan
- Reset then idle: hold `rst_n`=0 two cycles, release, no `start` → `class_id`=0, `max_score`=0, `busy`=0, `ready` never pulses.
- Single max: scores {3,-7,12,5,0,100,-1,99,42,7}, pulse `start` → exactly one `ready` pulse 10 cycles later, `class_id`=5, `max_score`=100.
- Signed and tie: all scores -32768 except class 2 and class 8 = -5 → `class_id`=2, `max_score`=-5; all scores equal 0 → `class_id`=0.
- Last-index winner and input hold: class 9 = 32767, others 0; change `data_in` to all 0 one cycle after `start` → `class_id`=9, `max_score`=32767.
- Busy rejection and back-to-back: second `start` 4 cycles after first (different data) → ignored, single `ready`; `start` asserted in the `ready` cycle → accepted, second `ready` 10 cycles after it with the second vector's result.
- Reset mid-scan: `start`, then `rst_n`=0 at cycle 5 for one cycle → no `ready`, outputs 0, `busy`=0; fresh `start` afterwards yields correct result.
